// File: rtl/tick_seq_detector.sv
`default_nettype none
// ============================================================================
// Module   : tick_seq_detector
// Brief    : Samples a serial bit on each divider tick and detects the
//            overlapping pattern 1011. Each detection gives a registered
//            one-cycle match pulse and bumps a saturating counter. A sticky
//            overflow flag records any match seen with the counter full.
// Revision : 1.0 - initial release
// ============================================================================
module tick_seq_detector #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low
  input  logic             tick,
  input  logic             din,
  input  logic             clr,
  output logic             match,
  output logic [2:0]       state,
  output logic [2:0]       nextstate,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,   // nothing useful seen
    S1   = 3'b001,   // seen "1"
    S10  = 3'b010,   // seen "10"
    S101 = 3'b011    // seen "101"
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_hit;
  logic             r_match;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  // State register; clr is folded into w_next so the register only needs reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and match decode; only a tick advances a legal state.
  always_comb begin
    w_next = r_state;
    w_hit  = 1'b0;
    if (clr) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (tick) w_next = din ? S1 : IDLE;
        S1:   if (tick) w_next = din ? S1 : S10;
        S10:  if (tick) w_next = din ? S101 : IDLE;
        S101: begin
          if (tick) begin
            // Both exits overlap: "1" of 1011 and "10" of 1010 are reused.
            if (din) begin
              w_next = S1;
              w_hit  = 1'b1;
            end else begin
              w_next = S10;
            end
          end
        end
        default: w_next = IDLE;  // illegal codes recover regardless of tick
      endcase
    end
  end

  // Match pulse, saturating counter and sticky overflow; clr beats a match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_match    <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_match    <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_hit) begin
        if (&r_count) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign match       = r_match;
  assign state       = r_state;
  assign nextstate   = w_next;
  assign match_count = r_count;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tick_seq_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_seq_detector
// Brief    : Directed bench for tick_seq_detector. Stimulus queues each
//            expected match (cycle, count, overflow); a monitor pops and
//            compares on every observed match pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_seq_detector;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tick = 1'b0;
  logic             din = 1'b0;
  logic             clr = 1'b0;
  logic             match;
  logic [2:0]       state;
  logic [2:0]       nextstate;
  logic [CNT_W-1:0] match_count;
  logic             overflow;

  typedef struct {
    int   cyc;
    int   cnt;
    logic ovf;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  tick_seq_detector #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .din        (din),
    .clr        (clr),
    .match      (match),
    .state      (state),
    .nextstate  (nextstate),
    .match_count(match_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Edge counter used to pin the exact cycle of each match pulse.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // One tick cycle followed by two idle cycles with din toggling in between.
  task automatic send(input logic d, input logic m, input int cnt, input logic ovf);
    exp_t e;
    @(negedge clk);
    tick = 1'b1;
    din  = d;
    if (m) begin
      e.cyc = cyc + 1;
      e.cnt = cnt;
      e.ovf = ovf;
      q.push_back(e);
    end
    @(negedge clk);
    tick = 1'b0;
    din  = ~d;
    @(negedge clk);
    din  = d;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Monitor: every match pulse must correspond to a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (match === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_match: got match=1 expected none (cyc=%0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("match_cycle", cyc, e.cyc);
          chk("match_count_at_match", int'(match_count), e.cnt);
          chk("overflow_at_match", int'(overflow), int'(e.ovf));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_match", int'(match), 0);
    chk("reset_count", int'(match_count), 0);
    chk("reset_overflow", int'(overflow), 0);
    reset = 1'b1;

    // Basic detection of 1011.
    send(1'b1, 1'b0, 0, 1'b0);
    send(1'b0, 1'b0, 0, 1'b0);
    send(1'b1, 1'b0, 0, 1'b0);
    chk("state_after_101", int'(state), 3);
    send(1'b1, 1'b1, 1, 1'b0);
    chk("state_after_1011", int'(state), 1);
    chk("count_after_1011", int'(match_count), 1);

    // Overlapping pair: 1,0,1,1,0,1,1.
    pulse_clr();
    chk("clr_count", int'(match_count), 0);
    chk("clr_state", int'(state), 0);
    send(1'b1, 1'b0, 0, 1'b0);
    send(1'b0, 1'b0, 0, 1'b0);
    send(1'b1, 1'b0, 0, 1'b0);
    send(1'b1, 1'b1, 1, 1'b0);
    send(1'b0, 1'b0, 0, 1'b0);
    send(1'b1, 1'b0, 0, 1'b0);
    send(1'b1, 1'b1, 2, 1'b0);
    chk("count_after_overlap", int'(match_count), 2);

    // No match for 1,0,0,1,1 with din toggling between ticks.
    pulse_clr();
    send(1'b1, 1'b0, 0, 1'b0);
    chk("nomatch_state_s1", int'(state), 1);
    chk("gated_nextstate", int'(nextstate), 1);
    send(1'b0, 1'b0, 0, 1'b0);
    chk("nomatch_state_s10", int'(state), 2);
    send(1'b0, 1'b0, 0, 1'b0);
    chk("nomatch_state_idle", int'(state), 0);
    send(1'b1, 1'b0, 0, 1'b0);
    send(1'b1, 1'b0, 0, 1'b0);
    chk("nomatch_state_end", int'(state), 1);
    chk("nomatch_count", int'(match_count), 0);

    // Saturation with a 2-bit counter: 1,2,3,3 and overflow on the 4th.
    pulse_clr();
    send(1'b1, 1'b0, 0, 1'b0);
    send(1'b0, 1'b0, 0, 1'b0);
    send(1'b1, 1'b0, 0, 1'b0);
    send(1'b1, 1'b1, 1, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      send(1'b0, 1'b0, 0, 1'b0);
      send(1'b1, 1'b0, 0, 1'b0);
      send(1'b1, 1'b1, (k > 3) ? 3 : k, (k == 4) ? 1'b1 : 1'b0);
    end
    send(1'b0, 1'b0, 0, 1'b0);
    chk("sat_count_hold", int'(match_count), 3);
    chk("sat_overflow_sticky", int'(overflow), 1);
    pulse_clr();
    chk("sat_clr_count", int'(match_count), 0);
    chk("sat_clr_overflow", int'(overflow), 0);
    chk("sat_clr_state", int'(state), 0);

    // clr coinciding with the completing tick suppresses the match.
    send(1'b1, 1'b0, 0, 1'b0);
    send(1'b0, 1'b0, 0, 1'b0);
    send(1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    tick = 1'b1;
    din  = 1'b1;
    clr  = 1'b1;
    #1 chk("clr_tick_nextstate", int'(nextstate), 0);
    @(negedge clk);
    tick = 1'b0;
    clr  = 1'b0;
    chk("clr_tick_match", int'(match), 0);
    chk("clr_tick_state", int'(state), 0);
    chk("clr_tick_count", int'(match_count), 0);

    // Async reset mid-pattern discards history.
    send(1'b1, 1'b0, 0, 1'b0);
    send(1'b0, 1'b0, 0, 1'b0);
    send(1'b1, 1'b0, 0, 1'b0);
    send(1'b1, 1'b1, 1, 1'b0);
    send(1'b0, 1'b0, 0, 1'b0);
    send(1'b1, 1'b0, 0, 1'b0);
    chk("pre_reset_state", int'(state), 3);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_state", int'(state), 0);
    chk("async_reset_count", int'(match_count), 0);
    chk("async_reset_match", int'(match), 0);
    @(negedge clk);
    reset = 1'b1;
    send(1'b1, 1'b0, 0, 1'b0);
    chk("post_reset_state", int'(state), 1);
    chk("post_reset_count", int'(match_count), 0);

    repeat (3) @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_match: got none expected match at cyc=%0d", e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tick_seq_detector.md
Name: tick_seq_detector

Overview:
- Downstream consumer of the divide-by-3 Moore FSM output `y`.
- Uses that one-cycle-in-three pulse as a sample strobe (`tick`) on a serial input `din`.
- Detects the bit pattern 1011 (overlapping) with a 4-state FSM, pulses `match`, and keeps a saturating count of detections.
- Exposes `state` and `nextstate` for debug, matching the divider's observability style.

Parameters:
- CNT_W, 8, width of the detection counter `match_count`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low forces every register to its reset value immediately; release is synchronous to clk.
- tick  input  1  sample strobe, driven by the divider `y`; one clk cycle wide.
- din  input  1  serial data bit, valid in cycles where tick=1.
- clr  input  1  synchronous clear of FSM, counter and overflow flag.
- match  output  1  registered one-cycle pulse per detected 1011.
- state  output  3  current FSM state.
- nextstate  output  3  combinational next state.
- match_count  output  CNT_W  saturating count of matches.
- overflow  output  1  sticky flag: a match occurred while `match_count` was already all-ones.

Behaviour:
- Reset (reset=0), async: state=IDLE, match=0, match_count=0, overflow=0.
- State encoding: IDLE=000, S1=001 (seen "1"), S10=010 (seen "10"), S101=011 (seen "101"). Codes 100..111 are illegal.
- FSM advances only on a rising edge with tick=1. With tick=0, nextstate=state and match<=0.
- Transitions (tick=1):
  - IDLE: din=1->S1, din=0->IDLE
  - S1: din=1->S1, din=0->S10
  - S10: din=1->S101, din=0->IDLE
  - S101: din=1->S1 with match, din=0->S10
  - Both S101 exits give overlap: suffix "1" of 1011 is reused, and suffix "10" of 1010 is reused.
- Illegal state (any tick value): nextstate=IDLE, no match.
- match latency: registered high for exactly the one clk cycle following the edge that samples the completing 1. Low in every other cycle. Back-to-back matches are impossible, since the minimum spacing is 3 ticks.
- match_count: increments by 1 in the same edge that sets match.
  - At 2^CNT_W-1 it holds (no wrap) and overflow<=1.
  - overflow stays 1 until clr or reset.
- clr=1 at an edge:
  - state<=IDLE, match<=0, match_count<=0, overflow<=0.
  - clr overrides a simultaneous tick/match: that match is neither pulsed nor counted.
- reset asserted mid-pattern: partial history is discarded. After release, detection restarts from IDLE; a pattern straddling the reset is not detected.
- din is ignored when tick=0. Glitches between ticks have no effect.
- `nextstate` is purely combinational from (state, tick, din, clr); clr=1 forces IDLE.

Test Plan:
- Reset, then tick every 3rd cycle, din per tick 1,0,1,1 -> match high one cycle after the 4th tick edge; match_count=1; state returns to S1 (001).
- Overlap: per-tick din 1,0,1,1,0,1,1 -> two match pulses, 3 ticks (9 clk) apart; match_count=2.
- Non-match and tick gating: per-tick din 1,0,0,1,1; din toggled every cycle between ticks -> no match, match_count=0; state only changes on tick edges.
- Saturation: CNT_W=2, drive 4 patterns -> count 1,2,3,3; overflow rises with the 4th match and stays 1. Then clr=1 for one cycle -> count=0, overflow=0, state=IDLE.
- Simultaneous clr with completing tick (state S101, din=1, tick=1, clr=1) -> match stays 0, count unchanged-to-0, state=IDLE.
- Async reset mid-pattern: after "101", pulse reset low between clk edges -> outputs zero immediately. Then one more tick with din=1 gives no match; state=S1.
